// File: rtl/lcd_serial_tx.sv
// Serial LCD transmitter: a small write FIFO of {is_cmd, data} words feeding a
// CS/RS/SCLK/SID shifter with configurable width, rate, bit order and burst framing.
module lcd_serial_tx #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1,
  parameter int CS_GAP     = 2,
  parameter int BURST      = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          I_we,
  input  logic                          I_is_cmd,
  input  logic [DATA_W-1:0]             I_data,
  input  logic                          I_clr_ovf,
  output logic [1:0]                    O_status,
  output logic                          O_full,
  output logic [$clog2(FIFO_DEPTH):0]   O_level,
  output logic                          O_overflow,
  output logic                          O_cs,
  output logic                          O_rs,
  output logic                          O_sclk,
  output logic                          O_sid
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int GAP_CYC = CS_GAP * CLK_DIV;
  localparam int CNT_W   = $clog2(GAP_CYC + 1);
  localparam int BIT_W   = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_READY    = 2'b00;
  localparam logic [1:0] ST_TRANSFER = 2'b01;
  localparam logic [1:0] ST_FINISH   = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_GAP} state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W:0] mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [AW:0]     level;
  logic            full, empty, push, pop, ovf;
  logic [DATA_W:0] head;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign push  = I_we && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {I_is_cmd, I_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      // A dropped write in the same cycle as a clear keeps the flag set.
      if (I_we && full)   ovf <= 1'b1;
      else if (I_clr_ovf) ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic                rs_q, rs_n;
  logic                div_done, last_bit;

  assign div_done = (cnt == CNT_W'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == BIT_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      rs_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      rs_q    <= rs_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    rs_n      = rs_q;
    pop       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shreg_n   = head[DATA_W-1:0];
          rs_n      = ~head[DATA_W];
          bit_cnt_n = BIT_W'(DATA_W);
          state_n   = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_n   = '0;
        state_n = S_LOW;
      end
      S_LOW: begin
        if (div_done) begin
          cnt_n   = '0;
          state_n = S_HIGH;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (div_done) begin
          cnt_n     = '0;
          bit_cnt_n = bit_cnt - BIT_W'(1);
          if (!last_bit) begin
            shreg_n = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
            state_n = S_LOW;
          end else if ((BURST != 0) && !empty && (~head[DATA_W] == rs_q)) begin
            // Burst continuation: next word goes straight to LOW with CS held.
            pop       = 1'b1;
            shreg_n   = head[DATA_W-1:0];
            bit_cnt_n = BIT_W'(DATA_W);
            state_n   = S_LOW;
          end else begin
            state_n = S_GAP;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        // Present the next word's RS while CS is low so it is settled before CS rises.
        if (!empty) rs_n = ~head[DATA_W];
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    if (state == S_HIGH && div_done && last_bit) O_status = ST_FINISH;
    else if (state == S_IDLE && empty)           O_status = ST_READY;
    else                                         O_status = ST_TRANSFER;
  end

  assign O_cs       = (state == S_LOAD) || (state == S_LOW) || (state == S_HIGH);
  assign O_sclk     = (state == S_HIGH);
  assign O_rs       = rs_q;
  assign O_sid      = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];
  assign O_full     = full;
  assign O_level    = level;
  assign O_overflow = ovf;

endmodule
